// File: rtl/alu_seq_if.sv
// Operand/result bus between the control unit and alu_seq.
// The master side is the control unit. It drives the operand bus, the load strobes,
// the function code, Start and Gout. The slave side is the ALU. It returns Busy, Done
// and the status flags.
interface alu_seq_if #(
    parameter int WIDTH = 10,
    parameter int FNW   = 4
);
    logic [WIDTH-1:0] OP;
    logic [FNW-1:0]   FN;
    logic             Ain;
    logic             Gin;
    logic             Start;
    logic             Gout;
    logic             Busy;
    logic             Done;
    logic [3:0]       Flags;

    modport master (
        output OP, FN, Ain, Gin, Start, Gout,
        input  Busy, Done, Flags
    );

    modport slave (
        input  OP, FN, Ain, Gin, Start, Gout,
        output Busy, Done, Flags
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU on the shared operand bus.
// - Operands A and G are latched from OP.
// - Single-cycle operations complete on the edge that samples Start.
// - A shift-add multiply takes WIDTH further edges.
// - R drives the tri-state bus Q only while Gout is high.
// - All state changes on the falling edge of CLKb. RSTb is an asynchronous, active-low reset.
// Build option: define ALU_SEQ_MUL_EN to include the multiplier (FN 1100). When the
// macro is undefined, FN 1100 behaves as an unknown code and Busy is tied low.
module alu_seq #(
    parameter int WIDTH = 10,
    parameter int FNW   = 4
) (
    input  logic             CLKb,
    input  logic             RSTb,
    alu_seq_if.slave         bus,
    output wire  [WIDTH-1:0] Q
);
    localparam int MSB = WIDTH - 1;

    localparam logic [FNW-1:0] FN_ADD = 4'b0010;
    localparam logic [FNW-1:0] FN_SUB = 4'b0011;
    localparam logic [FNW-1:0] FN_INV = 4'b0100;
    localparam logic [FNW-1:0] FN_FLP = 4'b0101;
    localparam logic [FNW-1:0] FN_AND = 4'b0110;
    localparam logic [FNW-1:0] FN_OR  = 4'b0111;
    localparam logic [FNW-1:0] FN_XOR = 4'b1000;
    localparam logic [FNW-1:0] FN_LSL = 4'b1001;
    localparam logic [FNW-1:0] FN_LSR = 4'b1010;
    localparam logic [FNW-1:0] FN_ASR = 4'b1011;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] g_reg;
    logic [WIDTH-1:0] r_reg;
    logic [3:0]       flags_reg;
    logic             done_reg;
    logic             frozen;

    // Single-cycle result path
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic             alu_known;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH-1:0] diff;

`ifdef ALU_SEQ_MUL_EN
    localparam logic [FNW-1:0] FN_MUL = 4'b1100;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    logic             busy_reg;
    logic [2*WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [CW-1:0]      cnt_reg;
    logic [2*WIDTH-1:0] acc_next;

    // One shift-add step: accumulate the shifted multiplicand when the multiplier LSB is set
    always_comb begin
        acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
    end

    assign frozen   = busy_reg;
    assign bus.Busy = busy_reg;
`else
    assign frozen   = 1'b0;
    assign bus.Busy = 1'b0;
`endif

    // Combinational evaluation of every single-cycle function on the held operands
    always_comb begin
        alu_res   = r_reg;
        alu_c     = 1'b0;
        alu_v     = 1'b0;
        alu_known = 1'b1;
        sum_ext   = {1'b0, a_reg} + {1'b0, g_reg};
        diff      = a_reg - g_reg;
        case (bus.FN)
            FN_ADD: begin
                alu_res = sum_ext[MSB:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = (a_reg[MSB] == g_reg[MSB]) && (sum_ext[MSB] != a_reg[MSB]);
            end
            FN_SUB: begin
                alu_res = diff;
                alu_c   = (a_reg >= g_reg);
                alu_v   = (a_reg[MSB] != g_reg[MSB]) && (diff[MSB] != a_reg[MSB]);
            end
            FN_INV: begin
                alu_res = -g_reg;
                alu_v   = (g_reg == MOST_NEG);
            end
            FN_FLP: alu_res = ~g_reg;
            FN_AND: alu_res = a_reg & g_reg;
            FN_OR:  alu_res = a_reg | g_reg;
            FN_XOR: alu_res = a_reg ^ g_reg;
            // Shift amounts >= WIDTH naturally yield 0 (logical) or sign fill (arithmetic)
            FN_LSL: alu_res = a_reg << g_reg;
            FN_LSR: alu_res = a_reg >> g_reg;
            FN_ASR: alu_res = $signed(a_reg) >>> g_reg;
            default: alu_known = 1'b0;
        endcase
    end

    // Operand latches, control FSM, result/flag registers and multiplier datapath
    always_ff @(negedge CLKb or negedge RSTb) begin
        if (!RSTb) begin
            state_reg  <= S_IDLE;
            a_reg      <= '0;
            g_reg      <= '0;
            r_reg      <= '0;
            flags_reg  <= '0;
            done_reg   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            busy_reg   <= 1'b0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
`endif
        end else begin
            done_reg <= 1'b0;
            // Operands stay frozen while a multiply is running
            if (!frozen) begin
                if (bus.Ain) a_reg <= bus.OP;
                if (bus.Gin) g_reg <= bus.OP;
            end
            case (state_reg)
                S_IDLE: begin
                    if (bus.Start) begin
                        // Unknown codes leave R/Flags alone but still pass through DONE
                        if (alu_known) begin
                            r_reg     <= alu_res;
                            flags_reg <= {alu_res == '0, alu_res[MSB], alu_c, alu_v};
                        end
                        done_reg  <= 1'b1;
                        state_reg <= S_DONE;
`ifdef ALU_SEQ_MUL_EN
                        // MUL decodes as unknown above, so R is untouched; redirect to MUL here
                        if (bus.FN == FN_MUL) begin
                            done_reg   <= 1'b0;
                            busy_reg   <= 1'b1;
                            state_reg  <= S_MUL;
                            mcand_reg  <= {{WIDTH{1'b0}}, a_reg};
                            mplier_reg <= g_reg;
                            acc_reg    <= '0;
                            cnt_reg    <= '0;
                        end
`endif
                    end
                end
`ifdef ALU_SEQ_MUL_EN
                S_MUL: begin
                    acc_reg    <= acc_next;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    cnt_reg    <= cnt_reg + CW'(1);
                    if (cnt_reg == LAST_STEP) begin
                        r_reg     <= acc_next[MSB:0];
                        flags_reg <= {acc_next[MSB:0] == '0, acc_next[MSB],
                                      |acc_next[2*WIDTH-1:WIDTH], 1'b0};
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= S_DONE;
                    end
                end
`endif
                S_DONE:  state_reg <= S_IDLE;
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign bus.Done  = done_reg;
    assign bus.Flags = flags_reg;
    assign Q         = bus.Gout ? r_reg : {WIDTH{1'bz}};
endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq (WIDTH=10). Inputs change on the rising edge and
// outputs are sampled there too, half a cycle after the falling active edge.
// The multiplier scenarios are compiled only when ALU_SEQ_MUL_EN is defined.
module tb_alu_seq;
    localparam int W = 10;
    localparam logic [3:0] ADD = 4'b0010, SUB = 4'b0011, INV = 4'b0100, FLP = 4'b0101;
    localparam logic [3:0] AND_ = 4'b0110, OR_ = 4'b0111, XOR_ = 4'b1000;
    localparam logic [3:0] LSL = 4'b1001, LSR = 4'b1010, ASR = 4'b1011, MUL = 4'b1100;

    logic         CLKb = 1'b0;
    logic         RSTb = 1'b0;
    wire  [W-1:0] q;
    int           n_checks = 0;
    int           n_pass   = 0;

    alu_seq_if #(.WIDTH(W), .FNW(4)) bus ();

    alu_seq #(.WIDTH(W), .FNW(4)) dut (
        .CLKb (CLKb),
        .RSTb (RSTb),
        .bus  (bus),
        .Q    (q)
    );

    always #5 CLKb = ~CLKb;

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge CLKb);
    endtask

    task automatic load(input logic [W-1:0] a, input logic [W-1:0] g);
        bus.OP = a; bus.Ain = 1'b1; cyc();
        bus.Ain = 1'b0; bus.OP = g; bus.Gin = 1'b1; cyc();
        bus.Gin = 1'b0;
    endtask

    task automatic pulse_start(input logic [3:0] fn);
        bus.FN = fn; bus.Start = 1'b1; cyc();
        bus.Start = 1'b0;
    endtask

    task automatic test_reset;
        RSTb = 1'b0; bus.Gout = 1'b1;
        cyc(2);
        n_checks++; if (q !== 10'h000) $display("FAIL reset_q: got %h want 000", q); else n_pass++;
        n_checks++; if (bus.Flags !== 4'b0000) $display("FAIL reset_flags: got %b want 0000", bus.Flags); else n_pass++;
        n_checks++; if (bus.Busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.Busy); else n_pass++;
        n_checks++; if (bus.Done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.Done); else n_pass++;
        RSTb = 1'b1;
        cyc();
        $display("reset: q=%h flags=%b", q, bus.Flags);
    endtask

    task automatic test_add;
        load(10'h3FF, 10'h001);
        pulse_start(ADD);
        $display("add 3ff+001: q=%h flags=%b done=%b", q, bus.Flags, bus.Done);
        n_checks++; if (bus.Done !== 1'b1) $display("FAIL add_done: got %b want 1", bus.Done); else n_pass++;
        n_checks++; if (q !== 10'h000) $display("FAIL add_r: got %h want 000", q); else n_pass++;
        n_checks++; if (bus.Flags !== 4'b1010) $display("FAIL add_flags: got %b want 1010", bus.Flags); else n_pass++;
        cyc();
        n_checks++; if (bus.Done !== 1'b0) $display("FAIL add_done_pulse: got %b want 0", bus.Done); else n_pass++;
        load(10'h1FF, 10'h001);
        pulse_start(ADD);
        $display("add 1ff+001: q=%h flags=%b", q, bus.Flags);
        n_checks++; if (q !== 10'h200) $display("FAIL addv_r: got %h want 200", q); else n_pass++;
        n_checks++; if (bus.Flags !== 4'b0101) $display("FAIL addv_flags: got %b want 0101", bus.Flags); else n_pass++;
        cyc();
    endtask

    task automatic test_sub_shift;
        load(10'd5, 10'd7);
        pulse_start(SUB);
        $display("sub 5-7: q=%h flags=%b", q, bus.Flags);
        n_checks++; if (q !== 10'h3FE) $display("FAIL sub_r: got %h want 3fe", q); else n_pass++;
        n_checks++; if (bus.Flags !== 4'b0100) $display("FAIL sub_flags: got %b want 0100", bus.Flags); else n_pass++;
        bus.Gout = 1'b0; #1;
        $display("gout=0: q=%h", q);
        n_checks++; if (q === 10'h3FE) $display("FAIL q_release: got %h want not 3fe (high-z)", q); else n_pass++;
        bus.Gout = 1'b1;
        cyc();
        load(10'h200, 10'd12);
        pulse_start(ASR);
        $display("asr 200>>>12: q=%h flags=%b", q, bus.Flags);
        n_checks++; if (q !== 10'h3FF) $display("FAIL asr_r: got %h want 3ff", q); else n_pass++;
        n_checks++; if (bus.Flags !== 4'b0100) $display("FAIL asr_flags: got %b want 0100", bus.Flags); else n_pass++;
        cyc();
        pulse_start(LSR);
        $display("lsr 200>>12: q=%h flags=%b", q, bus.Flags);
        n_checks++; if (q !== 10'h000) $display("FAIL lsr_r: got %h want 000", q); else n_pass++;
        n_checks++; if (bus.Flags !== 4'b1000) $display("FAIL lsr_flags: got %b want 1000", bus.Flags); else n_pass++;
        cyc();
        load(10'h0F3, 10'd3);
        pulse_start(LSL);
        $display("lsl 0f3<<3: q=%h flags=%b", q, bus.Flags);
        n_checks++; if (q !== 10'h398) $display("FAIL lsl_r: got %h want 398", q); else n_pass++;
        cyc();
    endtask

    task automatic test_logic;
        load(10'h0F0, 10'h3CC);
        pulse_start(AND_);
        $display("and: q=%h flags=%b", q, bus.Flags);
        n_checks++; if (q !== 10'h0C0) $display("FAIL and_r: got %h want 0c0", q); else n_pass++;
        n_checks++; if (bus.Flags !== 4'b0000) $display("FAIL and_flags: got %b want 0000", bus.Flags); else n_pass++;
        cyc();
        pulse_start(OR_);
        $display("or: q=%h", q);
        n_checks++; if (q !== 10'h3FC) $display("FAIL or_r: got %h want 3fc", q); else n_pass++;
        cyc();
        pulse_start(XOR_);
        $display("xor: q=%h", q);
        n_checks++; if (q !== 10'h33C) $display("FAIL xor_r: got %h want 33c", q); else n_pass++;
        cyc();
        load(10'h0F0, 10'h200);
        pulse_start(INV);
        $display("inv -200: q=%h flags=%b", q, bus.Flags);
        n_checks++; if (q !== 10'h200) $display("FAIL inv_r: got %h want 200", q); else n_pass++;
        n_checks++; if (bus.Flags !== 4'b0101) $display("FAIL inv_flags: got %b want 0101", bus.Flags); else n_pass++;
        cyc();
        pulse_start(FLP);
        $display("flp ~200: q=%h flags=%b", q, bus.Flags);
        n_checks++; if (q !== 10'h1FF) $display("FAIL flp_r: got %h want 1ff", q); else n_pass++;
        n_checks++; if (bus.Flags !== 4'b0000) $display("FAIL flp_flags: got %b want 0000", bus.Flags); else n_pass++;
        cyc();
    endtask

    task automatic test_back_to_back;
        load(10'd1, 10'd2);
        bus.FN = ADD; bus.Start = 1'b1; cyc();
        $display("b2b first add: q=%h done=%b", q, bus.Done);
        n_checks++; if (q !== 10'h003) $display("FAIL b2b_first: got %h want 003", q); else n_pass++;
        bus.FN = SUB; cyc();
        $display("b2b start in DONE: q=%h done=%b", q, bus.Done);
        n_checks++; if (q !== 10'h003) $display("FAIL b2b_ignored_r: got %h want 003", q); else n_pass++;
        n_checks++; if (bus.Done !== 1'b0) $display("FAIL b2b_ignored_done: got %b want 0", bus.Done); else n_pass++;
        cyc();
        $display("b2b second sub: q=%h done=%b", q, bus.Done);
        n_checks++; if (q !== 10'h3FF) $display("FAIL b2b_second: got %h want 3ff", q); else n_pass++;
        n_checks++; if (bus.Done !== 1'b1) $display("FAIL b2b_second_done: got %b want 1", bus.Done); else n_pass++;
        bus.Start = 1'b0; cyc();
        // Start and Ain on the same edge: old A used now, new A next time
        bus.OP = 10'h010; bus.Ain = 1'b1; bus.FN = ADD; bus.Start = 1'b1; cyc();
        bus.Ain = 1'b0; bus.Start = 1'b0;
        $display("same-edge load add: q=%h", q);
        n_checks++; if (q !== 10'h003) $display("FAIL same_edge_old: got %h want 003", q); else n_pass++;
        cyc();
        pulse_start(ADD);
        $display("add with new A: q=%h", q);
        n_checks++; if (q !== 10'h012) $display("FAIL same_edge_new: got %h want 012", q); else n_pass++;
        cyc();
    endtask

    task automatic test_unknown;
        load(10'd5, 10'd7);
        pulse_start(SUB);
        cyc();
        pulse_start(4'b1111);
        $display("fn 1111: q=%h flags=%b done=%b", q, bus.Flags, bus.Done);
        n_checks++; if (bus.Done !== 1'b1) $display("FAIL unk_done: got %b want 1", bus.Done); else n_pass++;
        n_checks++; if (q !== 10'h3FE) $display("FAIL unk_r: got %h want 3fe", q); else n_pass++;
        n_checks++; if (bus.Flags !== 4'b0100) $display("FAIL unk_flags: got %b want 0100", bus.Flags); else n_pass++;
        cyc();
        n_checks++; if (bus.Done !== 1'b0) $display("FAIL unk_done_pulse: got %b want 0", bus.Done); else n_pass++;
`ifndef ALU_SEQ_MUL_EN
        pulse_start(MUL);
        $display("fn 1100 (no mul): q=%h flags=%b done=%b busy=%b", q, bus.Flags, bus.Done, bus.Busy);
        n_checks++; if (bus.Done !== 1'b1) $display("FAIL nomul_done: got %b want 1", bus.Done); else n_pass++;
        n_checks++; if (bus.Busy !== 1'b0) $display("FAIL nomul_busy: got %b want 0", bus.Busy); else n_pass++;
        n_checks++; if (q !== 10'h3FE) $display("FAIL nomul_r: got %h want 3fe", q); else n_pass++;
        cyc();
`endif
    endtask

`ifdef ALU_SEQ_MUL_EN
    // Starts a multiply and waits (bounded) for Busy to drop; optionally pulses
    // Start and Ain with OP=0x155 mid-operation.
    task automatic run_mul(input bit disturb, output int cycles);
        pulse_start(MUL);
        n_checks++; if (bus.Busy !== 1'b1) $display("FAIL mul_busy_start: got %b want 1", bus.Busy); else n_pass++;
        cycles = 0;
        while (bus.Busy === 1'b1 && cycles < 40) begin
            bus.Start = disturb && (cycles == 3);
            bus.FN    = (cycles == 3) ? ADD : MUL;
            bus.Ain   = disturb && (cycles == 5);
            bus.OP    = 10'h155;
            cycles++;
            cyc();
        end
        bus.Start = 1'b0; bus.Ain = 1'b0;
    endtask

    task automatic test_mul;
        int cycles;
        load(10'd31, 10'd33);
        run_mul(1'b1, cycles);
        $display("mul 31*33: q=%h flags=%b busy_cycles=%0d done=%b", q, bus.Flags, cycles, bus.Done);
        n_checks++; if (cycles != 10) $display("FAIL mul_busy_len: got %0d want 10", cycles); else n_pass++;
        n_checks++; if (bus.Done !== 1'b1) $display("FAIL mul_done: got %b want 1", bus.Done); else n_pass++;
        n_checks++; if (q !== 10'h3FF) $display("FAIL mul_r: got %h want 3ff", q); else n_pass++;
        n_checks++; if (bus.Flags !== 4'b0100) $display("FAIL mul_flags: got %b want 0100", bus.Flags); else n_pass++;
        cyc();
        n_checks++; if (bus.Done !== 1'b0) $display("FAIL mul_done_pulse: got %b want 0", bus.Done); else n_pass++;
        pulse_start(OR_);
        $display("or after frozen load: q=%h", q);
        n_checks++; if (q !== 10'h03F) $display("FAIL mul_frozen_a: got %h want 03f", q); else n_pass++;
        cyc();
        load(10'd32, 10'd32);
        run_mul(1'b0, cycles);
        $display("mul 32*32: q=%h flags=%b", q, bus.Flags);
        n_checks++; if (q !== 10'h000) $display("FAIL mul2_r: got %h want 000", q); else n_pass++;
        n_checks++; if (bus.Flags !== 4'b1010) $display("FAIL mul2_flags: got %b want 1010", bus.Flags); else n_pass++;
        cyc();
    endtask
`endif

    task automatic test_reset_abort;
        int seen;
        load(10'd3, 10'd5);
        pulse_start(ADD);
        n_checks++; if (q !== 10'h008) $display("FAIL abort_pre: got %h want 008", q); else n_pass++;
        cyc();
`ifdef ALU_SEQ_MUL_EN
        pulse_start(MUL);
        cyc(4);
`else
        pulse_start(ADD);
`endif
        RSTb = 1'b0; #1;
        $display("reset mid-op: q=%h flags=%b busy=%b done=%b", q, bus.Flags, bus.Busy, bus.Done);
        n_checks++; if (q !== 10'h000) $display("FAIL abort_r: got %h want 000", q); else n_pass++;
        n_checks++; if (bus.Flags !== 4'b0000) $display("FAIL abort_flags: got %b want 0000", bus.Flags); else n_pass++;
        n_checks++; if (bus.Busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", bus.Busy); else n_pass++;
        n_checks++; if (bus.Done !== 1'b0) $display("FAIL abort_done: got %b want 0", bus.Done); else n_pass++;
        cyc();
        RSTb = 1'b1;
        seen = 0;
        repeat (15) begin
            cyc();
            if (bus.Done === 1'b1) seen++;
        end
        $display("after abort: done pulses=%0d q=%h", seen, q);
        n_checks++; if (seen != 0) $display("FAIL abort_no_done: got %0d want 0", seen); else n_pass++;
    endtask

    initial begin
        bus.OP = '0; bus.FN = '0; bus.Ain = 1'b0; bus.Gin = 1'b0;
        bus.Start = 1'b0; bus.Gout = 1'b1;
        test_reset();
        test_add();
        test_sub_shift();
        test_logic();
        test_back_to_back();
        test_unknown();
`ifdef ALU_SEQ_MUL_EN
        test_mul();
`endif
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised sequential ALU for the datapath, the successor to the fixed 10-bit ALU. It sits on the shared operand bus and latches operands A and G from `OP`. It computes into a result register with status flags and drives the bus from that register only when selected. Adds a `Start`/`Busy`/`Done` handshake so multi-cycle operations, such as the shift-add multiply, can be sequenced by the control unit.

## Interface
- `WIDTH`, 10, datapath width in bits (≥ 4)
- `FNW`, 4, function-code width
- `CLKb`  in  1  clock; all state updates on its falling edge
- `RSTb`  in  1  asynchronous active-low reset
- `OP`  in  WIDTH  operand bus input
- `FN`  in  FNW  function code, sampled with `Start`
- `Ain`  in  1  load `OP` into A
- `Gin`  in  1  load `OP` into G
- `Start`  in  1  begin operation `FN` on A, G
- `Gout`  in  1  drive R onto `Q`
- `Q`  out  WIDTH  R when `Gout`=1, else high-Z
- `Busy`  out  1  multi-cycle operation in progress
- `Done`  out  1  one-cycle pulse: R and flags updated
- `Flags`  out  4  {Z, N, C, V} for the last completed operation

## Operation
- Clock `CLKb` and reset `RSTb`: one clock; reset is asynchronous and active-low.
- Operand registers: `Ain`/`Gin` load A/G from `OP`; both may load on the same edge. Both are ignored while `Busy`=1, so operands stay frozen.
- FSM states:
  - IDLE: `Start`=1 with a single-cycle FN → write R and Flags → DONE. `Start` with MUL → MUL.
  - MUL: step the counter → DONE after WIDTH steps.
  - DONE: `Done`=1 → IDLE. `Start` is ignored in DONE and MUL.
- Function codes, with all arithmetic modulo 2^WIDTH:
  - 0010 add: A+G
  - 0011 sub: A−G
  - 0100 inv: −G
  - 0101 flp: ~G
  - 0110 and
  - 0111 or
  - 1000 xor
  - 1001 lsl: A<<G
  - 1010 lsr: A>>G
  - 1011 asr: signed A>>>G
  - 1100 mul: low WIDTH bits of A×G, unsigned
- Shift amounts: G is treated as unsigned.
  - G ≥ WIDTH: lsl/lsr give 0; asr gives all copies of A[WIDTH−1].
- Unknown FN: R and Flags unchanged; FSM still passes through DONE, so `Done` pulses.
- Flags:
  - Z = (R==0).
  - N = R[WIDTH−1].
  - add: C = carry-out; V = signed overflow.
  - sub: C = 1 iff A ≥ G unsigned; V = signed overflow.
  - inv: C = 0; V = 1 iff G is the most-negative value.
  - mul: C = 1 iff the high WIDTH bits of the product are nonzero; V = 0.
  - All other ops: C = V = 0.
- `Q` output: `Q` = R whenever `Gout`=1, independent of FSM state (shows the previous R while `Busy`); `Q` = 'z when `Gout`=0.

## Timing
- Reset values: A = G = R = 0, `Flags` = 0, `Busy` = 0, `Done` = 0, state IDLE. `Q` is high-Z, or 0 if `Gout`=1.
- Single-cycle op: `Start` seen at edge n → R/Flags valid after edge n, `Done`=1 from edge n to n+1.
- MUL:
  - `Start` at edge n latches the multiplicand, multiplier and product accumulator; `Busy`=1 after edge n.
  - Steps occur at edges n+1 … n+WIDTH; R and Flags are written at edge n+WIDTH.
  - `Busy`=0 and `Done`=1 for one cycle after edge n+WIDTH.
- `Start` and `Ain`/`Gin` on the same edge: the operation uses the old A/G; the new values load for the next operation.
- Back-to-back: the next `Start` is accepted in the IDLE state following DONE, i.e. at most one op every 2 edges.
- `RSTb` low mid-MUL: abort immediately; all registers return to reset values and no `Done` pulse is produced.

## Configuration
- `ALU_SEQ_MUL_EN` defined: MUL state, counter, accumulator and FN 1100 are present as above.
- `ALU_SEQ_MUL_EN` undefined: no multiplier logic and `Busy` is tied 0. FN 1100 is treated as unknown: R unchanged, `Done` pulses one cycle after `Start`.

## Test plan
- Reset: assert `RSTb`=0 with `Gout`=1 → `Q`=0x000, `Flags`=0, `Busy`=`Done`=0.
- Add (WIDTH=10): A=0x3FF, G=0x001, add → R=0x000, Z=1, C=1, V=0, `Done` one cycle after `Start`. Then `Gout`=0 → `Q`=z.
- Sub: A=5, G=7, sub → R=0x3FE, N=1, C=0, V=0. Then A=0x200, G=12, asr → R=0x3FF. Then lsr with the same operands → R=0x000.
- MUL: A=31, G=33 → `Busy` high for 10 cycles, R=0x3FF, C=0. Then A=32, G=32 → R=0x000, Z=1, C=1. `Start` pulsed mid-op is ignored.
- Mid-op operand load: during MUL, pulse `Ain` with `OP`=0x155 → A is unchanged after `Done`. Then drop `RSTb` at step 5 of a new MUL → no `Done`, R=0.
- Unknown FN 1111 → R and Flags unchanged, `Done` pulses once. With `ALU_SEQ_MUL_EN` undefined, FN 1100 behaves the same way.
